opensync_decap_param: RTL and testbench

Parametrised second-generation OpenSync receive decapsulator on the 1G MAC byte path. Classifies each incoming frame at a configurable byte offset against EtherType/subtype/type, extracts the 64-bit receive timestamp from matching frames, strips a configurable header and forwards the remainder. Non-matching frames pass unchanged with fixed latency. Adds a second message type, runt/truncation handling and a timestamp-valid strobe.

---
 rtl/opensync_decap_param.sv | 183 ++++++++++++++++++
 tb/tb_opensync_decap_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/opensync_decap_param.sv
// opensync_decap_param: OpenSync v2 receive decapsulator on the 1G MAC byte path.
// Classifies frames at a fixed byte offset, captures the 64-bit receive
// timestamp of OpenSync frames, strips their header and forwards the rest.
// Other frames pass through unchanged with LAT = ETH_OFS+4 cycles latency.
// Build macro OPENSYNC_DECAP_STATS_EN adds saturating pass/decap/drop counters.
module opensync_decap_param #(
  parameter logic [15:0] ETH_TYPE  = 16'hff01,
  parameter int          ETH_OFS   = 12,
  parameter logic [7:0]  SUBTYPE   = 8'h06,
  parameter logic [7:0]  TYPE_CF   = 8'h03,
  parameter logic [7:0]  TYPE_SYNC = 8'h04,
  parameter int          TS_OFS    = 16,
  parameter int          STRIP_LEN = 47
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  iv_data,
  input  logic        i_data_wr,
  output logic [7:0]  ov_data,
  output logic        o_data_wr,
  output logic [63:0] ov_receive_time,
  output logic        o_ts_valid,
  output logic        o_cf_update_flag,
  output logic [1:0]  ov_frame_type,
  output logic        o_runt_drop,
  output logic        o_trunc_err
`ifdef OPENSYNC_DECAP_STATS_EN
  ,
  output logic [31:0] ov_pass_cnt,
  output logic [31:0] ov_decap_cnt,
  output logic [31:0] ov_drop_cnt
`endif
);
  localparam int DEC = ETH_OFS + 3;
  localparam int LAT = DEC + 1;
  localparam logic [10:0] CNT_DEC   = 11'(DEC);
  localparam logic [10:0] CNT_TSEND = 11'(TS_OFS + 7);
  localparam logic [10:0] CNT_STRIP = 11'(STRIP_LEN);

  typedef enum logic [2:0] {IDLE, EXTRACT, STRIP, PASS, WAIT_GAP} state_e;
  state_e state_q, state_d;

  logic [10:0]         cnt_q;
  logic [LAT-1:0][7:0] dat_q;
  logic [LAT-1:0]      vld_pipe_q, mrk_pipe_q;
  logic                rst_done_q, in_match_q;
  logic [55:0]         ts_sh_q;
  logic [7:0]          data_q;
  logic                wr_q, ts_vld_q, cf_q, runt_q, trunc_q;
  logic [63:0]         rtime_q;
  logic [1:0]          ftype_q;

  logic       wr, dec_hit, hdr_ok, is_cf, is_sync, fend, runt, trunc;
  logic       out_v, ts_cap, drain_done;
  logic [7:0] out_d;

  // Bytes of a frame cut by reset are ignored until the next inter-frame gap.
  assign wr      = i_data_wr && rst_done_q && (state_q != WAIT_GAP);
  assign dec_hit = wr && (cnt_q == CNT_DEC);
  // At the decision byte the three preceding header bytes sit at the delay-line tail.
  assign hdr_ok  = ({dat_q[2], dat_q[1]} == ETH_TYPE) && (dat_q[0] == SUBTYPE);
  assign is_cf   = hdr_ok && (iv_data == TYPE_CF);
  assign is_sync = hdr_ok && (iv_data == TYPE_SYNC);
  assign fend    = !i_data_wr && (cnt_q != '0);
  assign runt    = fend && (cnt_q <= CNT_DEC);
  assign trunc   = fend && in_match_q && (cnt_q <= CNT_STRIP);

  // Next state and head-of-line output; a new decision overrides a draining PASS.
  always_comb begin
    state_d    = state_q;
    out_v      = 1'b0;
    out_d      = 8'h00;
    ts_cap     = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      IDLE:     if (!rst_done_q && i_data_wr) state_d = WAIT_GAP;
      WAIT_GAP: if (!i_data_wr) state_d = IDLE;
      EXTRACT: begin
        if (trunc) state_d = IDLE;
        else if (wr && cnt_q == CNT_TSEND) begin
          ts_cap  = 1'b1;
          state_d = STRIP;
        end
      end
      STRIP: begin
        if (trunc) state_d = IDLE;
        else if (vld_pipe_q[LAT-1] && mrk_pipe_q[LAT-1]) begin
          out_v   = 1'b1;
          out_d   = dat_q[LAT-1];
          state_d = PASS;
        end
      end
      PASS: begin
        if (vld_pipe_q[LAT-1]) begin
          out_v = 1'b1;
          out_d = dat_q[LAT-1];
        end else begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (dec_hit) state_d = (is_cf || is_sync) ? EXTRACT : PASS;
  end

  // State, byte counter, delay line and timestamp assembly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dat_q      <= '0;
      vld_pipe_q <= '0;
      mrk_pipe_q <= '0;
      rst_done_q <= 1'b0;
      in_match_q <= 1'b0;
      ts_sh_q    <= '0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
      cnt_q      <= !wr ? 11'd0 : (cnt_q == 11'h7ff) ? cnt_q : cnt_q + 11'd1;
      dat_q      <= {dat_q[LAT-2:0], iv_data};
      vld_pipe_q <= {vld_pipe_q[LAT-2:0], wr};
      mrk_pipe_q <= {mrk_pipe_q[LAT-2:0], wr && (cnt_q == CNT_STRIP)};
      if (!i_data_wr) in_match_q <= 1'b0;
      else if (dec_hit) in_match_q <= is_cf || is_sync;
      if (state_q == EXTRACT && wr) ts_sh_q <= {ts_sh_q[47:0], iv_data};
    end
  end

  // Registered outputs and event pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q   <= '0;
      wr_q     <= 1'b0;
      rtime_q  <= '0;
      ts_vld_q <= 1'b0;
      cf_q     <= 1'b0;
      ftype_q  <= '0;
      runt_q   <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      data_q   <= out_d;
      wr_q     <= out_v;
      ts_vld_q <= ts_cap;
      if (ts_cap) rtime_q <= {ts_sh_q, iv_data};
      cf_q     <= dec_hit && is_cf;
      if (dec_hit) ftype_q <= is_cf ? 2'd1 : is_sync ? 2'd2 : 2'd0;
      runt_q   <= runt;
      trunc_q  <= trunc;
    end
  end

  assign ov_data          = data_q;
  assign o_data_wr        = wr_q;
  assign ov_receive_time  = rtime_q;
  assign o_ts_valid       = ts_vld_q;
  assign o_cf_update_flag = cf_q;
  assign ov_frame_type    = ftype_q;
  assign o_runt_drop      = runt_q;
  assign o_trunc_err      = trunc_q;

`ifdef OPENSYNC_DECAP_STATS_EN
  logic [31:0] pass_cnt_q, decap_cnt_q, drop_cnt_q;

  // Frame counters: completed drains split by frame type, plus drop events.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pass_cnt_q  <= '0;
      decap_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (drain_done && ftype_q == 2'd0 && pass_cnt_q != '1)  pass_cnt_q  <= pass_cnt_q + 32'd1;
      if (drain_done && ftype_q != 2'd0 && decap_cnt_q != '1) decap_cnt_q <= decap_cnt_q + 32'd1;
      if ((runt || trunc) && drop_cnt_q != '1)                drop_cnt_q  <= drop_cnt_q + 32'd1;
    end
  end

  assign ov_pass_cnt  = pass_cnt_q;
  assign ov_decap_cnt = decap_cnt_q;
  assign ov_drop_cnt  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_opensync_decap_param.sv
// Bench for opensync_decap_param: frame-level reference model plus output monitor.
module tb_opensync_decap_param;
  localparam int LAT = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic [7:0]  iv_data = 8'h00;
  logic        i_data_wr = 1'b0;
  logic [7:0]  ov_data;
  logic        o_data_wr;
  logic [63:0] ov_receive_time;
  logic        o_ts_valid, o_cf_update_flag, o_runt_drop, o_trunc_err;
  logic [1:0]  ov_frame_type;
`ifdef OPENSYNC_DECAP_STATS_EN
  logic [31:0] ov_pass_cnt, ov_decap_cnt, ov_drop_cnt;
`endif

  opensync_decap_param dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .iv_data(iv_data), .i_data_wr(i_data_wr),
    .ov_data(ov_data), .o_data_wr(o_data_wr), .ov_receive_time(ov_receive_time),
    .o_ts_valid(o_ts_valid), .o_cf_update_flag(o_cf_update_flag),
    .ov_frame_type(ov_frame_type), .o_runt_drop(o_runt_drop), .o_trunc_err(o_trunc_err)
`ifdef OPENSYNC_DECAP_STATS_EN
    , .ov_pass_cnt(ov_pass_cnt), .ov_decap_cnt(ov_decap_cnt), .ov_drop_cnt(ov_drop_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor: cumulative record of everything the DUT emits.
  logic [7:0] got_q[$];
  int         gotc_q[$];
  int n_cf = 0, n_ts = 0, n_runt = 0, n_trunc = 0, bad_data = 0, cf_cyc = 0;
  always @(negedge i_clk) begin
    if (o_data_wr) begin
      got_q.push_back(ov_data);
      gotc_q.push_back(cyc);
    end else if (ov_data !== 8'h00) bad_data++;
    if (o_cf_update_flag) begin n_cf++; cf_cyc = cyc; end
    if (o_ts_valid) n_ts++;
    if (o_runt_drop) n_runt++;
    if (o_trunc_err) n_trunc++;
  end

  // Reference model state (expected cumulative results).
  logic [7:0]  frm[$];
  logic [7:0]  exp_q[$];
  int          e_cf = 0, e_ts = 0, e_runt = 0, e_trunc = 0;
  logic [63:0] m_ts = '0;
  logic [1:0]  m_type = '0;
  int          chk_idx = 0, in_cyc = 0;
  int          vecs = 0, errs = 0;

  task automatic put(input int idx, input logic [7:0] v);
    if (idx < frm.size()) frm[idx] = v;
  endtask

  // kind 0: ordinary Ethernet, 1: CF update, 2: sync, 3: OpenSync header with unknown type
  task automatic build(input int len, input int kind, input logic [63:0] ts);
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
    if (kind == 0) begin put(12, 8'h08); put(13, 8'h00); end
    else begin
      put(12, 8'hff); put(13, 8'h01); put(14, 8'h06);
      put(15, kind == 1 ? 8'h03 : kind == 2 ? 8'h04 : 8'h07);
      for (int i = 0; i < 8; i++) put(16 + i, ts[63-8*i -: 8]);
    end
  endtask

  // Frame-level rules: runt below 16 bytes, classify on bytes 12..15,
  // timestamp from bytes 16..23, matching frames lose their first 47 bytes.
  task automatic model_frame();
    int n;
    n = frm.size();
    if (n == 0) return;
    if (n < 16) begin e_runt++; return; end
    if (frm[12] == 8'hff && frm[13] == 8'h01 && frm[14] == 8'h06 &&
        (frm[15] == 8'h03 || frm[15] == 8'h04)) begin
      m_type = (frm[15] == 8'h03) ? 2'd1 : 2'd2;
      if (m_type == 2'd1) e_cf++;
      if (n >= 24) begin
        for (int i = 0; i < 8; i++) m_ts[63-8*i -: 8] = frm[16+i];
        e_ts++;
      end
      if (n <= 47) e_trunc++;
      else for (int i = 47; i < n; i++) exp_q.push_back(frm[i]);
    end else begin
      m_type = 2'd0;
      for (int i = 0; i < n; i++) exp_q.push_back(frm[i]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_clk); #1; i_data_wr = 1'b0; iv_data = 8'h00; end
  endtask

  task automatic send(input int gap);
    for (int i = 0; i < frm.size(); i++) begin
      @(posedge i_clk); #1;
      if (i == 0) in_cyc = cyc + 1;
      iv_data = frm[i]; i_data_wr = 1'b1;
    end
    idle(gap);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b1; #1; i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    vecs++; if (o_data_wr !== 1'b0) begin errs++; $display("FAIL reset o_data_wr got %b want 0", o_data_wr); end
    vecs++; if (ov_data !== 8'h00) begin errs++; $display("FAIL reset ov_data got %h want 00", ov_data); end
    vecs++; if (ov_receive_time !== 64'h0) begin errs++; $display("FAIL reset ov_receive_time got %h want 0", ov_receive_time); end
    vecs++; if ({o_ts_valid, o_cf_update_flag, o_runt_drop, o_trunc_err} !== 4'b0) begin
      errs++; $display("FAIL reset pulses got %b want 0000", {o_ts_valid, o_cf_update_flag, o_runt_drop, o_trunc_err}); end
    vecs++; if (ov_frame_type !== 2'd0) begin errs++; $display("FAIL reset ov_frame_type got %0d want 0", ov_frame_type); end
    i_rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_pass64();
    build(64, 0, '0); model_frame(); send(3); idle(LAT + 4);
    vecs++; if (got_q.size() !== exp_q.size()) begin errs++; $display("FAIL pass64 count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL pass64 byte %0d got %h want %h", i - chk_idx, got_q[i], exp_q[i]); break; end
    end
    if (got_q.size() >= chk_idx + 64) begin
      vecs++; if (gotc_q[chk_idx] - in_cyc !== LAT) begin errs++; $display("FAIL pass64 latency got %0d want %0d", gotc_q[chk_idx] - in_cyc, LAT); end
      vecs++; if (gotc_q[chk_idx+63] - gotc_q[chk_idx] !== 63) begin errs++; $display("FAIL pass64 span got %0d want 63", gotc_q[chk_idx+63] - gotc_q[chk_idx]); end
    end
    vecs++; if (ov_frame_type !== m_type) begin errs++; $display("FAIL pass64 type got %0d want %0d", ov_frame_type, m_type); end
    vecs++; if ({n_cf, n_ts, n_runt, n_trunc} !== {e_cf, e_ts, e_runt, e_trunc}) begin
      errs++; $display("FAIL pass64 pulses got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", n_cf, n_ts, n_runt, n_trunc, e_cf, e_ts, e_runt, e_trunc); end
    chk_idx = got_q.size();
  endtask

  task automatic test_decap(input int kind, input logic [63:0] ts);
    build(80, kind, ts); model_frame(); send(3); idle(LAT + 4);
    vecs++; if (got_q.size() !== exp_q.size()) begin errs++; $display("FAIL decap%0d count got %0d want %0d", kind, got_q.size(), exp_q.size()); end
    for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL decap%0d byte %0d got %h want %h", kind, i - chk_idx, got_q[i], exp_q[i]); break; end
    end
    if (got_q.size() > chk_idx) begin
      vecs++; if (gotc_q[chk_idx] - in_cyc !== 47 + LAT) begin errs++; $display("FAIL decap%0d first-out cycle got %0d want %0d", kind, gotc_q[chk_idx] - in_cyc, 47 + LAT); end
    end
    vecs++; if (n_cf !== e_cf) begin errs++; $display("FAIL decap%0d cf pulses got %0d want %0d", kind, n_cf, e_cf); end
    if (kind == 1) begin
      vecs++; if (cf_cyc - in_cyc !== 15) begin errs++; $display("FAIL decap1 cf cycle got %0d want 15", cf_cyc - in_cyc); end
    end
    vecs++; if (ov_receive_time !== m_ts) begin errs++; $display("FAIL decap%0d ts got %h want %h", kind, ov_receive_time, m_ts); end
    vecs++; if (n_ts !== e_ts) begin errs++; $display("FAIL decap%0d ts_valid got %0d want %0d", kind, n_ts, e_ts); end
    vecs++; if (ov_frame_type !== m_type) begin errs++; $display("FAIL decap%0d type got %0d want %0d", kind, ov_frame_type, m_type); end
    chk_idx = got_q.size();
  endtask

  task automatic test_runt_trunc();
    build(10, 0, '0); model_frame(); send(2);
    build(20, 1, {$urandom, $urandom}); model_frame(); send(2);
    idle(LAT + 4);
    vecs++; if (n_runt !== e_runt) begin errs++; $display("FAIL runt count got %0d want %0d", n_runt, e_runt); end
    vecs++; if (ov_receive_time !== m_ts) begin errs++; $display("FAIL trunc20 ts got %h want %h", ov_receive_time, m_ts); end
    build(30, 2, m_ts); model_frame(); send(2); idle(LAT + 4);
    vecs++; if (n_trunc !== e_trunc) begin errs++; $display("FAIL trunc count got %0d want %0d", n_trunc, e_trunc); end
    vecs++; if (n_ts !== e_ts) begin errs++; $display("FAIL trunc30 ts_valid got %0d want %0d", n_ts, e_ts); end
    vecs++; if (ov_receive_time !== m_ts) begin errs++; $display("FAIL trunc30 ts got %h want %h", ov_receive_time, m_ts); end
    vecs++; if (got_q.size() !== exp_q.size()) begin errs++; $display("FAIL runt_trunc output got %0d want %0d", got_q.size(), exp_q.size()); end
    chk_idx = got_q.size();
  endtask

  task automatic test_back_to_back();
    int b;
    b = chk_idx;
    build(64, 0, '0); model_frame(); send(1);
    build(64, 0, '0); model_frame(); send(1);
    idle(LAT + 4);
    vecs++; if (got_q.size() !== exp_q.size()) begin errs++; $display("FAIL b2b count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = b; i < exp_q.size() && i < got_q.size(); i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL b2b byte %0d got %h want %h", i - b, got_q[i], exp_q[i]); break; end
    end
    if (got_q.size() >= b + 128) begin
      vecs++; if (gotc_q[b+64] - gotc_q[b+63] !== 2) begin errs++; $display("FAIL b2b gap got %0d want 2", gotc_q[b+64] - gotc_q[b+63]); end
      vecs++; if (gotc_q[b+127] - gotc_q[b+64] !== 63) begin errs++; $display("FAIL b2b span2 got %0d want 63", gotc_q[b+127] - gotc_q[b+64]); end
    end
    chk_idx = got_q.size();
  endtask

  task automatic test_reset_mid();
    build(80, 1, {$urandom, $urandom});
    for (int i = 0; i <= 20; i++) begin @(posedge i_clk); #1; iv_data = frm[i]; i_data_wr = 1'b1; end
    #2; i_rst_n = 1'b0; #1;
    e_cf++; m_ts = '0; m_type = 2'd0;
    vecs++; if ({o_data_wr, ov_data, o_cf_update_flag, o_ts_valid} !== 11'h0) begin errs++; $display("FAIL rstmid data/pulses got %h want 0", {o_data_wr, ov_data, o_cf_update_flag, o_ts_valid}); end
    vecs++; if (ov_frame_type !== 2'd0) begin errs++; $display("FAIL rstmid type got %0d want 0", ov_frame_type); end
    vecs++; if (ov_receive_time !== 64'h0) begin errs++; $display("FAIL rstmid ts got %h want 0", ov_receive_time); end
    @(posedge i_clk); #1; iv_data = frm[21];
    @(posedge i_clk); #1; i_rst_n = 1'b1; iv_data = frm[22];
    for (int i = 23; i < 80; i++) begin @(posedge i_clk); #1; iv_data = frm[i]; end
    idle(2);
    build(64, 0, '0); model_frame(); send(1);
    build(64, 1, {$urandom, $urandom}); model_frame(); send(2);
    idle(LAT + 4);
    vecs++; if (got_q.size() !== exp_q.size()) begin errs++; $display("FAIL rstmid count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL rstmid byte %0d got %h want %h", i - chk_idx, got_q[i], exp_q[i]); break; end
    end
    vecs++; if (ov_receive_time !== m_ts) begin errs++; $display("FAIL rstmid next ts got %h want %h", ov_receive_time, m_ts); end
    vecs++; if ({n_cf, n_ts, n_runt, n_trunc} !== {e_cf, e_ts, e_runt, e_trunc}) begin
      errs++; $display("FAIL rstmid pulses got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", n_cf, n_ts, n_runt, n_trunc, e_cf, e_ts, e_runt, e_trunc); end
    chk_idx = got_q.size();
  endtask

  task automatic test_random();
    for (int f = 0; f < 60; f++) begin
      build($urandom_range(120, 1), $urandom_range(3, 0), {$urandom, $urandom});
      model_frame();
      send($urandom_range(3, 1));
    end
    idle(LAT + 4);
    vecs++; if (got_q.size() !== exp_q.size()) begin errs++; $display("FAIL random count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL random byte %0d got %h want %h", i, got_q[i], exp_q[i]); break; end
    end
    vecs++; if ({n_cf, n_ts, n_runt, n_trunc} !== {e_cf, e_ts, e_runt, e_trunc}) begin
      errs++; $display("FAIL random pulses got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", n_cf, n_ts, n_runt, n_trunc, e_cf, e_ts, e_runt, e_trunc); end
    vecs++; if (ov_receive_time !== m_ts) begin errs++; $display("FAIL random ts got %h want %h", ov_receive_time, m_ts); end
    vecs++; if (ov_frame_type !== m_type) begin errs++; $display("FAIL random type got %0d want %0d", ov_frame_type, m_type); end
    vecs++; if (bad_data !== 0) begin errs++; $display("FAIL idle ov_data nonzero cycles got %0d want 0", bad_data); end
    chk_idx = got_q.size();
  endtask

  initial begin
    test_reset();
    test_pass64();
    test_decap(1, 64'h0102030405060708);
    test_decap(2, {$urandom, $urandom});
    test_runt_trunc();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
